mem_port_arbiter: RTL and testbench

Arbitrates the multicycle core's single shared memory port between the core (instruction fetch and load/store) and a debug/DMA loader port. Each requester gets a req/ready handshake. The arbiter drives the memory for a fixed number of wait cycles and returns read data with a one-cycle ready pulse. The core's main control FSM holds its current state (FETCH, MEMRD, MEMWR) until `c_ready` is asserted.

---
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between the core and a debug/DMA loader.
//            Each access runs for MEM_LAT cycles and then gives the requester
//            a one-cycle ready pulse. Contended grants alternate fairly.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  // core port
  input  logic          i_c_req,
  input  logic          i_c_we,
  input  logic [AW-1:0] i_c_addr,
  input  logic [DW-1:0] i_c_wdata,
  output logic [DW-1:0] o_c_rdata,
  output logic          o_c_ready,
  // debug port
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_d_ready,
  // memory side
  output logic          o_m_en,
  output logic          o_m_we,
  output logic [AW-1:0] o_m_addr,
  output logic [DW-1:0] o_m_wdata,
  input  logic [DW-1:0] i_m_rdata,
  // status
  output logic          o_owner,
  output logic          o_busy
);

  // Wait counter preload; MEM_LAT is limited to 1..15 so 4 bits suffice.
  localparam logic [3:0] C_CNT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last;      // owner of the most recently completed access
  logic [3:0]    r_cnt;
  logic          r_owner;
  logic          r_busy;
  logic          r_m_en;
  logic          r_m_we;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_wdata;
  logic [DW-1:0] r_c_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_c_ready;
  logic          r_d_ready;

  logic          w_gnt;       // a new access starts at the next edge
  logic          w_gnt_dbg;   // 1 = debug port wins that grant
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  // Grant decision: ties in IDLE go to the port that was not served last;
  // from DONE only the other port may be granted.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_dbg = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_c_req && i_d_req) begin
          w_gnt     = 1'b1;
          w_gnt_dbg = ~r_last;
        end else if (i_c_req) begin
          w_gnt     = 1'b1;
          w_gnt_dbg = 1'b0;
        end else if (i_d_req) begin
          w_gnt     = 1'b1;
          w_gnt_dbg = 1'b1;
        end
      end
      S_DONE: begin
        if (!r_owner && i_d_req) begin
          w_gnt     = 1'b1;
          w_gnt_dbg = 1'b1;
        end else if (r_owner && i_c_req) begin
          w_gnt     = 1'b1;
          w_gnt_dbg = 1'b0;
        end
      end
      default: begin
        w_gnt     = 1'b0;
        w_gnt_dbg = 1'b0;
      end
    endcase
  end

  // Request fields of whichever port is being granted.
  always_comb begin
    w_sel_we    = w_gnt_dbg ? i_d_we    : i_c_we;
    w_sel_addr  = w_gnt_dbg ? i_d_addr  : i_c_addr;
    w_sel_wdata = w_gnt_dbg ? i_d_wdata : i_c_wdata;
  end

  // Arbiter FSM with all outputs registered; reset abandons any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_cnt     <= 4'd0;
      r_owner   <= 1'b0;
      r_busy    <= 1'b0;
      r_m_en    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
      r_c_ready <= 1'b0;
      r_d_ready <= 1'b0;
    end else begin
      r_c_ready <= 1'b0;
      r_d_ready <= 1'b0;
      if (w_gnt) begin
        r_owner   <= w_gnt_dbg;
        r_m_we    <= w_sel_we;
        r_m_addr  <= w_sel_addr;
        r_m_wdata <= w_sel_wdata;
        r_cnt     <= C_CNT_INIT;
        r_m_en    <= 1'b1;
        r_busy    <= 1'b1;
        r_state   <= S_ACCESS;
      end else begin
        case (r_state)
          S_ACCESS: begin
            if (r_cnt != 4'd0) begin
              r_cnt <= r_cnt - 4'd1;
            end else begin
              if (!r_m_we) begin
                if (r_owner) r_d_rdata <= i_m_rdata;
                else         r_c_rdata <= i_m_rdata;
              end
              if (r_owner) r_d_ready <= 1'b1;
              else         r_c_ready <= 1'b1;
              r_last  <= r_owner;
              r_m_en  <= 1'b0;
              r_m_we  <= 1'b0;
              r_state <= S_DONE;
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_m_en  <= 1'b0;
            r_m_we  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_c_rdata = r_c_rdata;
  assign o_c_ready = r_c_ready;
  assign o_d_rdata = r_d_rdata;
  assign o_d_ready = r_d_ready;
  assign o_m_en    = r_m_en;
  assign o_m_we    = r_m_we;
  assign o_m_addr  = r_m_addr;
  assign o_m_wdata = r_m_wdata;
  assign o_owner   = r_owner;
  assign o_busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed bench for mem_port_arbiter (MEM_LAT 2, 1 and 15 builds)
//            with a small behavioural memory behind the main instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clk;
  logic reset;

  // main instance (MEM_LAT = 2)
  logic        c_req, c_we, d_req, d_we;
  logic [7:0]  c_addr, d_addr;
  logic [15:0] c_wdata, d_wdata, c_rdata, d_rdata;
  logic        c_ready, d_ready;
  logic        m_en, m_we, owner, busy;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata, m_rdata;

  // MEM_LAT = 1 and MEM_LAT = 15 instances (core reads only)
  logic        l1_req, l15_req;
  logic [7:0]  l1_addr, l15_addr;
  logic [15:0] l1_rdata, l15_rdata, l1_drdata, l15_drdata;
  logic        l1_ready, l15_ready, l1_dready, l15_dready;
  logic        l1_m_en, l1_m_we, l15_m_en, l15_m_we, l1_owner, l15_owner;
  logic        l1_busy, l15_busy;
  logic [7:0]  l1_m_addr, l15_m_addr;
  logic [15:0] l1_m_wdata, l15_m_wdata, l1_m_rdata, l15_m_rdata;

  logic [15:0] mem [256];

  int checks;
  int errors;

  mem_port_arbiter #(.AW(8), .DW(16), .MEM_LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_rdata(c_rdata), .o_c_ready(c_ready),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_rdata(d_rdata), .o_d_ready(d_ready),
    .o_m_en(m_en), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
    .i_m_rdata(m_rdata), .o_owner(owner), .o_busy(busy)
  );

  mem_port_arbiter #(.AW(8), .DW(16), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .i_c_req(l1_req), .i_c_we(1'b0), .i_c_addr(l1_addr), .i_c_wdata(16'h0),
    .o_c_rdata(l1_rdata), .o_c_ready(l1_ready),
    .i_d_req(1'b0), .i_d_we(1'b0), .i_d_addr(8'h0), .i_d_wdata(16'h0),
    .o_d_rdata(l1_drdata), .o_d_ready(l1_dready),
    .o_m_en(l1_m_en), .o_m_we(l1_m_we), .o_m_addr(l1_m_addr), .o_m_wdata(l1_m_wdata),
    .i_m_rdata(l1_m_rdata), .o_owner(l1_owner), .o_busy(l1_busy)
  );

  mem_port_arbiter #(.AW(8), .DW(16), .MEM_LAT(15)) u_dut_l15 (
    .clk(clk), .reset(reset),
    .i_c_req(l15_req), .i_c_we(1'b0), .i_c_addr(l15_addr), .i_c_wdata(16'h0),
    .o_c_rdata(l15_rdata), .o_c_ready(l15_ready),
    .i_d_req(1'b0), .i_d_we(1'b0), .i_d_addr(8'h0), .i_d_wdata(16'h0),
    .o_d_rdata(l15_drdata), .o_d_ready(l15_dready),
    .o_m_en(l15_m_en), .o_m_we(l15_m_we), .o_m_addr(l15_m_addr), .o_m_wdata(l15_m_wdata),
    .i_m_rdata(l15_m_rdata), .o_owner(l15_owner), .o_busy(l15_busy)
  );

  // Memory: asynchronous read, writes land on each enabled write cycle.
  assign m_rdata     = mem[m_addr];
  assign l1_m_rdata  = mem[l1_m_addr];
  assign l15_m_rdata = mem[l15_m_addr];

  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] = m_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int en1, en15, rk1, rk15;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = 8'h0; c_wdata = 16'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h0; d_wdata = 16'h0;
    l1_req = 1'b0; l1_addr = 8'h0; l15_req = 1'b0; l15_addr = 8'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h12] = 16'hBEEF;
    mem[8'h20] = 16'h1111;
    mem[8'h30] = 16'h2222;
    mem[8'h50] = 16'h5555;
    mem[8'h60] = 16'h6666;

    // ---- reset values ----
    @(negedge clk); @(negedge clk);
    chk("rst_m_en",    m_en,    0);
    chk("rst_m_we",    m_we,    0);
    chk("rst_m_addr",  m_addr,  0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_c_ready", c_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_owner",   owner,   0);
    chk("rst_busy",    busy,    0);
    reset = 1'b0;
    tick();

    // ---- single core read of 0x12 ----
    c_req = 1'b1; c_addr = 8'h12;
    tick();  // edge 0: grant
    chk("t1_en_c1",   m_en,   1);
    chk("t1_addr_c1", m_addr, 8'h12);
    chk("t1_busy",    busy,   1);
    chk("t1_rdy_c1",  c_ready, 0);
    tick();
    chk("t1_en_c2",   m_en,   1);
    chk("t1_rdy_c2",  c_ready, 0);
    tick();
    chk("t1_en_c3",   m_en,    0);
    chk("t1_rdy_c3",  c_ready, 1);
    chk("t1_rdata",   c_rdata, 16'hBEEF);
    chk("t1_d_rdy",   d_ready, 0);
    c_req = 1'b0;
    tick();
    chk("t1_rdy_off", c_ready, 0);
    chk("t1_idle",    busy,    0);

    // ---- debug write 0xA5A5 to 0x40, then core read of 0x40 ----
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = 16'hA5A5;
    tick();
    chk("t2_owner", owner,   1);
    chk("t2_we1",   m_we,    1);
    chk("t2_wdata", m_wdata, 16'hA5A5);
    tick();
    chk("t2_we2",   m_we,    1);
    tick();
    chk("t2_d_rdy", d_ready, 1);
    chk("t2_we_off", m_we,   0);
    d_req = 1'b0; d_we = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h40;
    tick();
    chk("t2_c_owner", owner, 0);
    chk("t2_c_we",    m_we,  0);
    tick();
    chk("t2_c_we2",   m_we,  0);
    tick();
    chk("t2_c_rdy",   c_ready, 1);
    chk("t2_c_rdata", c_rdata, 16'hA5A5);
    chk("t2_d_rdata", d_rdata, 16'h0000);
    chk("t2_d_rdy",   d_ready, 0);
    c_req = 1'b0;
    tick();

    // ---- simultaneous requests straight from reset ----
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    c_req = 1'b1; c_addr = 8'h20;
    d_req = 1'b1; d_addr = 8'h30;
    tick();  // edge 0: core wins the first tie
    chk("t3_owner0", owner,  0);
    chk("t3_addr0",  m_addr, 8'h20);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("t3_c_rdy_k%0d", k), c_ready, (k == 2 || k == 8)  ? 1 : 0);
      chk($sformatf("t3_d_rdy_k%0d", k), d_ready, (k == 5 || k == 11) ? 1 : 0);
      if (k == 3) chk("t3_dbg_addr", m_addr, 8'h30);
      if (k == 2 || k == 8) begin
        chk($sformatf("t3_owner_k%0d", k), owner, 0);
        chk($sformatf("t3_crd_k%0d", k), c_rdata, 16'h1111);
      end
      if (k == 5 || k == 11) begin
        chk($sformatf("t3_owner_k%0d", k), owner, 1);
        chk($sformatf("t3_drd_k%0d", k), d_rdata, 16'h2222);
        if (k == 11) begin
          c_req = 1'b0;
          d_req = 1'b0;
        end
      end
    end
    chk("t3_idle", busy, 0);

    // ---- core holds req through ready: one IDLE cycle, gap MEM_LAT+2 ----
    c_req = 1'b1; c_addr = 8'h50;
    tick();  // edge 0
    tick();
    tick();  // edge 2
    chk("t4_rdy1", c_ready, 1);
    tick();  // edge 3: DONE must not re-grant the core
    chk("t4_no_gnt_en", m_en, 0);
    chk("t4_idle_busy", busy, 0);
    chk("t4_rdy_k3",    c_ready, 0);
    tick();  // edge 4: grant from IDLE
    chk("t4_en_k4",  m_en,    1);
    chk("t4_rdy_k4", c_ready, 0);
    tick();
    chk("t4_rdy_k5", c_ready, 0);
    tick();  // edge 6
    chk("t4_rdy2",   c_ready, 1);
    chk("t4_rdata",  c_rdata, 16'h5555);
    c_req = 1'b0;
    tick();

    // ---- reset during the second access cycle of a core write ----
    c_req = 1'b1; c_we = 1'b1; c_addr = 8'h60; c_wdata = 16'h7777;
    tick();
    chk("t5_we1", m_we, 1);
    tick();
    chk("t5_en2", m_en, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_en",    m_en,    0);
    chk("t5_rst_we",    m_we,    0);
    chk("t5_rst_rdy",   c_ready, 0);
    chk("t5_rst_busy",  busy,    0);
    chk("t5_rst_rdata", c_rdata, 0);
    c_req = 1'b0; c_we = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    tick();
    chk("t5_no_rdy", c_ready, 0);
    c_req = 1'b1; c_addr = 8'h12;
    tick();
    tick();
    chk("t5_rd_rdy_early", c_ready, 0);
    tick();
    chk("t5_rd_rdy",   c_ready, 1);
    chk("t5_rd_rdata", c_rdata, 16'hBEEF);
    c_req = 1'b0;
    tick();

    // ---- MEM_LAT = 1 and MEM_LAT = 15 builds, single read each ----
    en1 = 0; en15 = 0; rk1 = -1; rk15 = -1;
    l1_req = 1'b1;  l1_addr = 8'h12;
    l15_req = 1'b1; l15_addr = 8'h12;
    for (int k = 0; k < 40; k++) begin
      tick();  // state after edge k
      if (l1_m_en)  en1++;
      if (l15_m_en) en15++;
      if (l1_ready && rk1 < 0) begin
        rk1 = k;
        l1_req = 1'b0;
      end
      if (l15_ready && rk15 < 0) begin
        rk15 = k;
        l15_req = 1'b0;
      end
    end
    chk("t6_l1_en_width",  en1,  1);
    chk("t6_l1_rdy_edge",  rk1,  1);
    chk("t6_l1_rdata",     l1_rdata, 16'hBEEF);
    chk("t6_l15_en_width", en15, 15);
    chk("t6_l15_rdy_edge", rk15, 15);
    chk("t6_l15_rdata",    l15_rdata, 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
